// File: rtl/ctrl_pipe_hazard_if.sv
// Signal bundle between the ID-stage control source and ctrl_pipe_hazard:
// instruction fields in, hazard controls and stage control words out.
interface ctrl_pipe_hazard_if;
  logic [9:0]  ctrl_in;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic        branch_taken;
  logic        stall_id;
  logic        flush_ifid;
  logic        ex_regdst;
  logic        ex_alusrc;
  logic        ex_branch;
  logic        ex_jump;
  logic [1:0]  ex_aluop;
  logic [4:0]  ex_dest;
  logic        mem_memread;
  logic        mem_memwrite;
  logic        mem_regwrite;
  logic [4:0]  mem_dest;
  logic        wb_regwrite;
  logic        wb_memtoreg;
  logic [4:0]  wb_dest;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output ctrl_in, id_rs, id_rt, id_rd, branch_taken,
    input  stall_id, flush_ifid, ex_regdst, ex_alusrc, ex_branch, ex_jump,
    input  ex_aluop, ex_dest, mem_memread, mem_memwrite, mem_regwrite, mem_dest,
    input  wb_regwrite, wb_memtoreg, wb_dest, stall_cnt, flush_cnt
  );

  modport slave (
    input  ctrl_in, id_rs, id_rt, id_rd, branch_taken,
    output stall_id, flush_ifid, ex_regdst, ex_alusrc, ex_branch, ex_jump,
    output ex_aluop, ex_dest, mem_memread, mem_memwrite, mem_regwrite, mem_dest,
    output wb_regwrite, wb_memtoreg, wb_dest, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/ctrl_pipe_hazard.sv
// Control-path pipeline (ID/EX, EX/MEM, MEM/WB) with load-use stall, branch/jump flush.
// Optional hazard statistics counters are built when HAZARD_STATS_EN is defined.
module ctrl_pipe_hazard (
  input  logic               clk,
  input  logic               rst_n,
  ctrl_pipe_hazard_if.slave  bus
);
  // Control word bit positions: {RegDst, ALUOp[1:0], ALUSrc, Branch, Jump, MemRead, MemWrite, RegWrite, MemtoReg}
  localparam int unsigned B_REGDST = 9;
  localparam int unsigned B_JUMP   = 4;
  localparam int unsigned B_MEMRD  = 3;
  localparam int unsigned B_REGWR  = 1;
  localparam int unsigned B_M2R    = 0;

  // Unknown bits must never propagate as asserted controls.
  function automatic logic clean_bit(input logic b);
    case (b)
      1'b1:    clean_bit = 1'b1;
      default: clean_bit = 1'b0;
    endcase
  endfunction

  function automatic logic [9:0] sanitise(input logic [9:0] w);
    logic [9:0] s;
    for (int i = 0; i < 10; i++) begin
      s[i] = clean_bit(w[i]);
    end
    if (!s[B_REGWR]) begin
      s[B_REGDST] = 1'b0;
      s[B_M2R]    = 1'b0;
    end
    return s;
  endfunction

  logic [9:0] r_ex_ctrl;
  logic [4:0] r_ex_dest;
  logic [3:0] r_mem_ctrl;
  logic [4:0] r_mem_dest;
  logic [1:0] r_wb_ctrl;
  logic [4:0] r_wb_dest;

  logic [9:0] w_ctrl;
  logic [4:0] w_dest;
  logic       w_load_use;
  logic       w_bubble;
  logic       w_stall;
  logic       w_flush;

  // Capture-side decode and hazard resolution (branch > load-use > jump).
  always_comb begin
    w_ctrl     = sanitise(bus.ctrl_in);
    w_dest     = 5'd0;
    if (w_ctrl[B_REGWR]) begin
      w_dest = w_ctrl[B_REGDST] ? bus.id_rd : bus.id_rt;
    end else begin
      w_dest = 5'd0;
    end
    w_load_use = r_ex_ctrl[B_MEMRD] && (r_ex_dest != 5'd0) &&
                 ((r_ex_dest == bus.id_rs) || (r_ex_dest == bus.id_rt));
    w_bubble   = bus.branch_taken || w_load_use;
    w_stall    = !bus.branch_taken && w_load_use;
    w_flush    = bus.branch_taken || (!w_load_use && w_ctrl[B_JUMP]);
  end

  // Stage registers; later stages advance unconditionally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_ctrl  <= 10'd0;
      r_ex_dest  <= 5'd0;
      r_mem_ctrl <= 4'd0;
      r_mem_dest <= 5'd0;
      r_wb_ctrl  <= 2'd0;
      r_wb_dest  <= 5'd0;
    end else begin
      if (w_bubble) begin
        r_ex_ctrl <= 10'd0;
        r_ex_dest <= 5'd0;
      end else begin
        r_ex_ctrl <= w_ctrl;
        r_ex_dest <= w_dest;
      end
      r_mem_ctrl <= r_ex_ctrl[3:0];
      r_mem_dest <= r_ex_dest;
      r_wb_ctrl  <= {r_mem_ctrl[B_REGWR], r_mem_ctrl[B_M2R]};
      r_wb_dest  <= r_mem_dest;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  // Saturating hazard event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (w_flush && (r_flush_cnt != 16'hFFFF)) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;
`else
  assign bus.stall_cnt = 16'd0;
  assign bus.flush_cnt = 16'd0;
`endif

  assign bus.stall_id     = w_stall;
  assign bus.flush_ifid   = w_flush;
  assign bus.ex_regdst    = r_ex_ctrl[9];
  assign bus.ex_aluop     = r_ex_ctrl[8:7];
  assign bus.ex_alusrc    = r_ex_ctrl[6];
  assign bus.ex_branch    = r_ex_ctrl[5];
  assign bus.ex_jump      = r_ex_ctrl[4];
  assign bus.ex_dest      = r_ex_dest;
  assign bus.mem_memread  = r_mem_ctrl[3];
  assign bus.mem_memwrite = r_mem_ctrl[2];
  assign bus.mem_regwrite = r_mem_ctrl[1];
  assign bus.mem_dest     = r_mem_dest;
  assign bus.wb_regwrite  = r_wb_ctrl[1];
  assign bus.wb_memtoreg  = r_wb_ctrl[0];
  assign bus.wb_dest      = r_wb_dest;
endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Directed, table-driven bench for ctrl_pipe_hazard plus reset and counter sequences.
module tb_ctrl_pipe_hazard;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  ctrl_pipe_hazard_if bus();

  ctrl_pipe_hazard dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [9:0] C_NOP = 10'b0000000000;
  localparam logic [9:0] C_RT  = 10'b1100000010;
  localparam logic [9:0] C_LW  = 10'b0001001011;
  localparam logic [9:0] C_J   = 10'b0000010000;
  localparam logic [9:0] C_SWX = 10'bx00100010x;

  typedef struct {
    logic [9:0] ctrl;
    logic [4:0] rs, rt, rd;
    logic       bt;
    logic       stall, flush;
    logic [5:0] ex;
    logic [4:0] ex_dest;
    logic [2:0] mem;
    logic [4:0] mem_dest;
    logic [1:0] wb;
    logic [4:0] wb_dest;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [9:0] c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic bt);
    bus.ctrl_in      = c;
    bus.id_rs        = rs;
    bus.id_rt        = rt;
    bus.id_rd        = rd;
    bus.branch_taken = bt;
  endtask

  function automatic logic [5:0] ex_word();
    return {bus.ex_regdst, bus.ex_aluop, bus.ex_alusrc, bus.ex_branch, bus.ex_jump};
  endfunction

  function automatic logic [31:0] all_outs();
    return {bus.stall_id, bus.flush_ifid, ex_word(), bus.ex_dest,
            bus.mem_memread, bus.mem_memwrite, bus.mem_regwrite, bus.mem_dest,
            bus.wb_regwrite, bus.wb_memtoreg, bus.wb_dest} | {16'd0, bus.stall_cnt | bus.flush_cnt};
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    drive(C_NOP, 5'd0, 5'd0, 5'd0, 1'b0);

    //          ctrl   rs     rt     rd     bt    stl   fl    ex         exd    mem     memd   wb     wbd
    vecs[0]  = '{C_RT,  5'd1,  5'd2,  5'd8,  1'b0, 1'b0, 1'b0, 6'b110000, 5'd8,  3'b000, 5'd0,  2'b00, 5'd0};
    vecs[1]  = '{C_NOP, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 6'b000000, 5'd0,  3'b001, 5'd8,  2'b00, 5'd0};
    vecs[2]  = '{C_NOP, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 6'b000000, 5'd0,  3'b000, 5'd0,  2'b10, 5'd8};
    vecs[3]  = '{C_LW,  5'd1,  5'd9,  5'd0,  1'b0, 1'b0, 1'b0, 6'b000100, 5'd9,  3'b000, 5'd0,  2'b00, 5'd0};
    vecs[4]  = '{C_RT,  5'd9,  5'd3,  5'd10, 1'b0, 1'b1, 1'b0, 6'b000000, 5'd0,  3'b101, 5'd9,  2'b00, 5'd0};
    vecs[5]  = '{C_RT,  5'd9,  5'd3,  5'd10, 1'b0, 1'b0, 1'b0, 6'b110000, 5'd10, 3'b000, 5'd0,  2'b11, 5'd9};
    vecs[6]  = '{C_LW,  5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 6'b000100, 5'd0,  3'b001, 5'd10, 2'b00, 5'd0};
    vecs[7]  = '{C_NOP, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 6'b000000, 5'd0,  3'b101, 5'd0,  2'b10, 5'd10};
    vecs[8]  = '{C_LW,  5'd2,  5'd5,  5'd0,  1'b0, 1'b0, 1'b0, 6'b000100, 5'd5,  3'b000, 5'd0,  2'b11, 5'd0};
    vecs[9]  = '{C_RT,  5'd1,  5'd5,  5'd7,  1'b1, 1'b0, 1'b1, 6'b000000, 5'd0,  3'b101, 5'd5,  2'b00, 5'd0};
    vecs[10] = '{C_J,   5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 6'b000001, 5'd0,  3'b000, 5'd0,  2'b11, 5'd5};
    vecs[11] = '{C_SWX, 5'd1,  5'd6,  5'd4,  1'b0, 1'b0, 1'b0, 6'b000100, 5'd0,  3'b000, 5'd0,  2'b00, 5'd0};
    vecs[12] = '{C_NOP, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 6'b000000, 5'd0,  3'b010, 5'd0,  2'b00, 5'd0};
    vecs[13] = '{C_NOP, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 6'b000000, 5'd0,  3'b000, 5'd0,  2'b00, 5'd0};
    vecs[14] = '{C_RT,  5'd1,  5'd2,  5'd3,  1'b1, 1'b0, 1'b1, 6'b000000, 5'd0,  3'b000, 5'd0,  2'b00, 5'd0};
    vecs[15] = '{C_LW,  5'd0,  5'd4,  5'd0,  1'b0, 1'b0, 1'b0, 6'b000100, 5'd4,  3'b000, 5'd0,  2'b00, 5'd0};
    vecs[16] = '{C_J,   5'd4,  5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 6'b000000, 5'd0,  3'b101, 5'd4,  2'b00, 5'd0};
    vecs[17] = '{C_J,   5'd4,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 6'b000001, 5'd0,  3'b000, 5'd0,  2'b11, 5'd4};

    // Reset state, before and after a clock edge with rst_n held low
    #3;
    chk("reset_outs_t3", all_outs(), 32'd0);
    @(posedge clk); #1;
    chk("reset_outs_edge", all_outs(), 32'd0);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].ctrl, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].bt);
      #1;
      chk($sformatf("v%0d_stall", i), {31'd0, bus.stall_id},   {31'd0, vecs[i].stall});
      chk($sformatf("v%0d_flush", i), {31'd0, bus.flush_ifid}, {31'd0, vecs[i].flush});
      @(posedge clk); #1;
      chk($sformatf("v%0d_ex", i),       {26'd0, ex_word()},     {26'd0, vecs[i].ex});
      chk($sformatf("v%0d_ex_dest", i),  {27'd0, bus.ex_dest},   {27'd0, vecs[i].ex_dest});
      chk($sformatf("v%0d_mem", i),      {29'd0, bus.mem_memread, bus.mem_memwrite, bus.mem_regwrite},
                                         {29'd0, vecs[i].mem});
      chk($sformatf("v%0d_mem_dest", i), {27'd0, bus.mem_dest},  {27'd0, vecs[i].mem_dest});
      chk($sformatf("v%0d_wb", i),       {30'd0, bus.wb_regwrite, bus.wb_memtoreg}, {30'd0, vecs[i].wb});
      chk($sformatf("v%0d_wb_dest", i),  {27'd0, bus.wb_dest},   {27'd0, vecs[i].wb_dest});
    end

`ifdef HAZARD_STATS_EN
    chk("stall_cnt_table", {16'd0, bus.stall_cnt}, 32'd2);
    chk("flush_cnt_table", {16'd0, bus.flush_cnt}, 32'd4);
`else
    chk("stall_cnt_table", {16'd0, bus.stall_cnt}, 32'd0);
    chk("flush_cnt_table", {16'd0, bus.flush_cnt}, 32'd0);
`endif

    // Asynchronous reset in the middle of a load-use stall
    drive(C_LW, 5'd0, 5'd9, 5'd0, 1'b0);
    @(posedge clk); #1;
    drive(C_RT, 5'd9, 5'd3, 5'd12, 1'b0);
    #1;
    chk("pre_reset_stall", {31'd0, bus.stall_id}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outs", all_outs(), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_ex", {26'd0, ex_word()}, {26'd0, 6'b110000});
    chk("post_reset_dest", {27'd0, bus.ex_dest}, 32'd12);
    chk("post_reset_stall_cnt", {16'd0, bus.stall_cnt}, 32'd0);

    // Flush counter saturation: branch_taken held every cycle
    drive(C_NOP, 5'd0, 5'd0, 5'd0, 1'b1);
    repeat (65540) @(posedge clk);
    #1;
`ifdef HAZARD_STATS_EN
    chk("flush_cnt_sat", {16'd0, bus.flush_cnt}, 32'h0000FFFF);
`else
    chk("flush_cnt_sat", {16'd0, bus.flush_cnt}, 32'd0);
`endif
    chk("stall_cnt_after_sat", {16'd0, bus.stall_cnt}, 32'd0);
    chk("sat_flush_out", {31'd0, bus.flush_ifid}, 32'd1);
    chk("sat_ex_bubble", {26'd0, ex_word()}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
